// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED register-port arbiter.
// Holds the FSM state type, register map and index-width helper.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int unsigned LED_ADDR_W = 2;
  localparam int unsigned LED_DATA_W = 8;

  localparam logic [LED_ADDR_W-1:0] REG_LED  = 2'd0;
  localparam logic [LED_ADDR_W-1:0] REG_RGBA = 2'd1;
  localparam logic [LED_ADDR_W-1:0] REG_RGBB = 2'd2;
  localparam logic [LED_ADDR_W-1:0] REG_RSVD = 2'd3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bus_arb_if.sv
// Requester-side bundle of the LED arbiter: valid/ready requests and response pulses.
// req_lock exists only when LED_ARB_LOCK_EN is defined.
interface led_bus_arb_if import led_arb_pkg::*; #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = LED_ADDR_W,
  parameter int unsigned DATA_W = LED_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
`ifdef LED_ARB_LOCK_EN
  logic [N_REQ-1:0]        req_lock;
`endif
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  // Requesters drive the request channel.
  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
`ifdef LED_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  // The arbiter accepts requests and returns responses.
  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
`ifdef LED_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first valid requester after i_last, with wrap.
module rr_pick import led_arb_pkg::*; #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= int'(N); k++) begin
      w_cand = (int'(i_last) + k) % int'(N);
      if (!o_any && i_valid[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = IDX_W'(w_cand);
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bus_arb.sv
// Round-robin arbiter sequencing N_REQ requesters onto the single LED register port.
// Optional burst locking is enabled by defining LED_ARB_LOCK_EN.
module led_bus_arb import led_arb_pkg::*; #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned ADDR_W = LED_ADDR_W,
  parameter int unsigned DATA_W = LED_DATA_W
`ifdef LED_ARB_LOCK_EN
  ,
  parameter int unsigned MAX_BURST = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  led_bus_arb_if.slave      req_bus,
  output logic [ADDR_W-1:0] o_led_addr,
  output logic [DATA_W-1:0] o_led_wdata,
  output logic              o_led_we,
  input  logic [DATA_W-1:0] i_led_rdata,
  output logic              o_busy
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  state_e             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_owner;
  logic [ADDR_W-1:0]  r_led_addr;
  logic [DATA_W-1:0]  r_led_wdata;
  logic               r_led_we;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_busy;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_hs;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [N_REQ-1:0]   w_owner_oh;
  logic [IDX_W-1:0]   w_next_last;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .i_valid (req_bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_bus.req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_hs              = (r_state == IDLE) && w_any;
  assign w_sel_addr        = req_bus.req_addr[w_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata       = req_bus.req_wdata[w_idx*DATA_W +: DATA_W];
  assign w_owner_oh        = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

`ifdef LED_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_burst_cnt;
  logic [IDX_W-1:0] r_burst_owner;
  logic [CNT_W-1:0] w_cnt_next;

  // A locked grant parks last_grant just before the winner so it rescans first,
  // until MAX_BURST consecutive locked grants force normal rotation.
  always_comb begin
    w_next_last = w_idx;
    w_cnt_next  = '0;
    if (req_bus.req_lock[w_idx]) begin
      w_cnt_next = (w_idx == r_burst_owner) ? r_burst_cnt + 1'b1 : CNT_W'(1);
      if (w_cnt_next >= CNT_W'(MAX_BURST)) begin
        w_cnt_next = '0;
      end else begin
        w_next_last = (w_idx == '0) ? IDX_W'(N_REQ - 1) : w_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt   <= '0;
      r_burst_owner <= '0;
    end else if (w_hs) begin
      r_burst_cnt   <= w_cnt_next;
      r_burst_owner <= w_idx;
    end
  end
`else
  assign w_next_last = w_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= IDX_W'(N_REQ - 1);
      r_owner     <= '0;
      r_led_addr  <= '0;
      r_led_wdata <= '0;
      r_led_we    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_owner     <= w_idx;
            r_led_we    <= req_bus.req_we[w_idx];
            r_led_addr  <= w_sel_addr;
            r_led_wdata <= w_sel_wdata;
            r_last      <= w_next_last;
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Register block read data is combinational on led_addr, valid this cycle.
          r_rsp_rdata <= r_led_we ? '0 : i_led_rdata;
          r_led_we    <= 1'b0;
          r_rsp_valid <= w_owner_oh;
          r_state     <= RESP;
        end
        RESP: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_bus.rsp_valid = r_rsp_valid;
  assign req_bus.rsp_rdata = r_rsp_rdata;
  assign o_led_addr        = r_led_addr;
  assign o_led_wdata       = r_led_wdata;
  assign o_led_we          = r_led_we;
  assign o_busy            = r_busy;

endmodule
